// File: rtl/conv2d_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_frame_scheduler
// Purpose  : Front-end sequencer for a single Conv2D3x3 core. After reset it
//            streams one full kernel into the core, then grants whole input
//            frames from two requesters in round-robin order. Each output
//            beat is tagged with the owning requester id and the last beat of
//            every frame is marked. Kernel reloads are taken between frames,
//            once the core has drained every frame in flight.
// Ports    : i_aclk / i_areset         clock, async active-high reset
//            i_kernel_* / o_kernel_*   kernel source stream (in)
//            i_kernel_reload           reload request pulse
//            i_s0_* / o_s0_*           requester 0 frame stream (in)
//            i_s1_* / o_s1_*           requester 1 frame stream (in)
//            o_conv_kernel_*           kernel stream to the core
//            o_conv_*                  frame stream to the core
//            i_conv_out_*              core result stream (in)
//            o_m_*                     tagged result stream (tid, tlast)
//            o_kernel_loaded           a complete kernel is resident
//            o_busy                    not idle, or frames in flight
//            o_err                     sticky: core output with nothing in flight
// Revision : 1.0 - initial release
// ============================================================================
module conv2d_frame_scheduler #(
    parameter int IN_HEIGHT        = 5,
    parameter int IN_WIDTH         = 4,
    parameter int IN_CHANNEL       = 4,
    parameter int WIDTH            = 16,
    parameter int WORD_WIDTH       = 8,
    parameter int FILTERS          = 8,
    parameter int KERNEL_BUF_WIDTH = 32,
    parameter int OUT_BEATS        = 24,
    parameter int ID_FIFO_DEPTH    = 4,
    localparam int c_OW            = (KERNEL_BUF_WIDTH / WIDTH) * WORD_WIDTH
) (
    input  logic                        i_aclk,
    input  logic                        i_areset,
    input  logic                        i_kernel_tvalid,
    output logic                        o_kernel_tready,
    input  logic [KERNEL_BUF_WIDTH-1:0] i_kernel_tdata,
    input  logic                        i_kernel_reload,
    input  logic                        i_s0_tvalid,
    output logic                        o_s0_tready,
    input  logic [WIDTH-1:0]            i_s0_tdata,
    input  logic                        i_s1_tvalid,
    output logic                        o_s1_tready,
    input  logic [WIDTH-1:0]            i_s1_tdata,
    output logic                        o_conv_kernel_tvalid,
    input  logic                        i_conv_kernel_tready,
    output logic [KERNEL_BUF_WIDTH-1:0] o_conv_kernel_tdata,
    output logic                        o_conv_tvalid,
    input  logic                        i_conv_tready,
    output logic [WIDTH-1:0]            o_conv_tdata,
    input  logic                        i_conv_out_tvalid,
    output logic                        o_conv_out_tready,
    input  logic [c_OW-1:0]             i_conv_out_tdata,
    output logic                        o_m_tvalid,
    input  logic                        i_m_tready,
    output logic [c_OW-1:0]             o_m_tdata,
    output logic                        o_m_tid,
    output logic                        o_m_tlast,
    output logic                        o_kernel_loaded,
    output logic                        o_busy,
    output logic                        o_err
);

    localparam int c_IN_BEATS     = IN_HEIGHT * IN_WIDTH * IN_CHANNEL * WORD_WIDTH / WIDTH;
    localparam int c_KERNEL_BEATS = 9 * FILTERS * IN_CHANNEL * WORD_WIDTH / KERNEL_BUF_WIDTH;
    localparam int c_KCNT_W       = $clog2(c_KERNEL_BEATS);
    localparam int c_ICNT_W       = $clog2(c_IN_BEATS);
    localparam int c_OCNT_W       = $clog2(OUT_BEATS);
    localparam int c_PTR_W        = $clog2(ID_FIFO_DEPTH);

    localparam logic [1:0] c_S_KERNEL = 2'd0;
    localparam logic [1:0] c_S_IDLE   = 2'd1;
    localparam logic [1:0] c_S_FRAME  = 2'd2;

    logic [1:0]          r_state;
    logic [c_KCNT_W-1:0] r_kcnt;
    logic [c_ICNT_W-1:0] r_icnt;
    logic [c_OCNT_W-1:0] r_out_cnt;
    logic                r_sel;
    logic                r_rr_ptr;
    logic                r_reload_pending;
    logic                r_kernel_loaded;
    logic                r_err;

    // Requester-id FIFO: one entry per frame granted but not yet fully output
    logic                r_id_mem [ID_FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_fifo_cnt;

    logic w_in_kernel;
    logic w_in_idle;
    logic w_in_frame;
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_kernel_hs;
    logic w_frame_hs;
    logic w_reload_go;
    logic w_grant;
    logic w_grant_id;
    logic w_out_hs;
    logic w_pop;

    assign w_in_kernel  = (r_state == c_S_KERNEL);
    assign w_in_idle    = (r_state == c_S_IDLE);
    assign w_in_frame   = (r_state == c_S_FRAME);
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == (c_PTR_W+1)'(ID_FIFO_DEPTH));

    // Kernel passthrough, only open while loading
    assign o_conv_kernel_tvalid = w_in_kernel & i_kernel_tvalid;
    assign o_kernel_tready      = w_in_kernel & i_conv_kernel_tready;
    assign o_conv_kernel_tdata  = i_kernel_tdata;
    assign w_kernel_hs          = w_in_kernel & i_kernel_tvalid & i_conv_kernel_tready;

    // Frame mux: only the granted requester sees the core's ready
    assign o_conv_tvalid = w_in_frame & (r_sel ? i_s1_tvalid : i_s0_tvalid);
    assign o_conv_tdata  = r_sel ? i_s1_tdata : i_s0_tdata;
    assign o_s0_tready   = w_in_frame & ~r_sel & i_conv_tready;
    assign o_s1_tready   = w_in_frame &  r_sel & i_conv_tready;
    assign w_frame_hs    = o_conv_tvalid & i_conv_tready;

    // Idle-state decisions; a pending reload outranks and blocks grants
    assign w_reload_go = w_in_idle & r_reload_pending & w_fifo_empty & (r_out_cnt == '0);
    assign w_grant     = w_in_idle & ~r_reload_pending & ~w_fifo_full &
                         (i_s0_tvalid | i_s1_tvalid);
    assign w_grant_id  = (i_s0_tvalid & i_s1_tvalid) ? r_rr_ptr : i_s1_tvalid;

    // Result side. With nothing in flight the beat is swallowed (ready=1,
    // valid hidden) so a misbehaving core cannot wedge the output.
    assign o_m_tvalid        = i_conv_out_tvalid & ~w_fifo_empty;
    assign o_conv_out_tready = w_fifo_empty | i_m_tready;
    assign o_m_tdata         = i_conv_out_tdata;
    assign o_m_tid           = r_id_mem[r_rd_ptr];
    assign o_m_tlast         = (r_out_cnt == c_OCNT_W'(OUT_BEATS - 1));
    assign w_out_hs          = o_m_tvalid & i_m_tready;
    assign w_pop             = w_out_hs & o_m_tlast;

    assign o_kernel_loaded = r_kernel_loaded;
    assign o_err           = r_err;
    assign o_busy          = ~w_in_idle | ~w_fifo_empty;

    // Sequencer / arbiter
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state          <= c_S_KERNEL;
            r_kcnt           <= '0;
            r_icnt           <= '0;
            r_sel            <= 1'b0;
            r_rr_ptr         <= 1'b0;
            r_reload_pending <= 1'b0;
            r_kernel_loaded  <= 1'b0;
        end else begin
            if (i_kernel_reload && !w_in_kernel) begin
                r_reload_pending <= 1'b1;
            end
            case (r_state)
                c_S_KERNEL: begin
                    if (w_kernel_hs) begin
                        if (r_kcnt == c_KCNT_W'(c_KERNEL_BEATS - 1)) begin
                            r_kcnt          <= '0;
                            r_kernel_loaded <= 1'b1;
                            r_state         <= c_S_IDLE;
                        end else begin
                            r_kcnt <= r_kcnt + 1'b1;
                        end
                    end
                end
                c_S_IDLE: begin
                    if (w_reload_go) begin
                        r_kernel_loaded  <= 1'b0;
                        r_reload_pending <= 1'b0;
                        r_state          <= c_S_KERNEL;
                    end else if (w_grant) begin
                        r_sel   <= w_grant_id;
                        r_state <= c_S_FRAME;
                    end
                end
                c_S_FRAME: begin
                    if (w_frame_hs) begin
                        if (r_icnt == c_ICNT_W'(c_IN_BEATS - 1)) begin
                            r_icnt   <= '0;
                            r_rr_ptr <= ~r_sel;
                            r_state  <= c_S_IDLE;
                        end else begin
                            r_icnt <= r_icnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_S_KERNEL;
            endcase
        end
    end

    // Id FIFO, output beat counter and error flag
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int i = 0; i < ID_FIFO_DEPTH; i++) begin
                r_id_mem[i] <= 1'b0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_out_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_id_mem[r_wr_ptr] <= w_grant_id;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_out_hs) begin
                r_out_cnt <= w_pop ? '0 : r_out_cnt + 1'b1;
            end
            if (i_conv_out_tvalid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2d_frame_scheduler
// Purpose  : Self-checking bench for conv2d_frame_scheduler. The bench plays
//            the requesters, the kernel source, the convolution core and the
//            result sink. Arbitration scenarios come from a vector table;
//            reload, FIFO-full, error and reset cases are hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv2d_frame_scheduler;

    localparam int KW         = 32;
    localparam int W          = 16;
    localparam int OW         = 16;
    localparam int IN_BEATS   = 40;
    localparam int KERN_BEATS = 72;
    localparam int OUT_BEATS  = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_kernel_tvalid, o_kernel_tready;
    logic [KW-1:0] i_kernel_tdata;
    logic          i_kernel_reload;
    logic          i_s0_tvalid, o_s0_tready;
    logic [W-1:0]  i_s0_tdata;
    logic          i_s1_tvalid, o_s1_tready;
    logic [W-1:0]  i_s1_tdata;
    logic          o_conv_kernel_tvalid, i_conv_kernel_tready;
    logic [KW-1:0] o_conv_kernel_tdata;
    logic          o_conv_tvalid, i_conv_tready;
    logic [W-1:0]  o_conv_tdata;
    logic          i_conv_out_tvalid, o_conv_out_tready;
    logic [OW-1:0] i_conv_out_tdata;
    logic          o_m_tvalid, i_m_tready;
    logic [OW-1:0] o_m_tdata;
    logic          o_m_tid, o_m_tlast;
    logic          o_kernel_loaded, o_busy, o_err;

    conv2d_frame_scheduler dut (
        .i_aclk               (clk),
        .i_areset             (rst),
        .i_kernel_tvalid      (i_kernel_tvalid),
        .o_kernel_tready      (o_kernel_tready),
        .i_kernel_tdata       (i_kernel_tdata),
        .i_kernel_reload      (i_kernel_reload),
        .i_s0_tvalid          (i_s0_tvalid),
        .o_s0_tready          (o_s0_tready),
        .i_s0_tdata           (i_s0_tdata),
        .i_s1_tvalid          (i_s1_tvalid),
        .o_s1_tready          (o_s1_tready),
        .i_s1_tdata           (i_s1_tdata),
        .o_conv_kernel_tvalid (o_conv_kernel_tvalid),
        .i_conv_kernel_tready (i_conv_kernel_tready),
        .o_conv_kernel_tdata  (o_conv_kernel_tdata),
        .o_conv_tvalid        (o_conv_tvalid),
        .i_conv_tready        (i_conv_tready),
        .o_conv_tdata         (o_conv_tdata),
        .i_conv_out_tvalid    (i_conv_out_tvalid),
        .o_conv_out_tready    (o_conv_out_tready),
        .i_conv_out_tdata     (i_conv_out_tdata),
        .o_m_tvalid           (o_m_tvalid),
        .i_m_tready           (i_m_tready),
        .o_m_tdata            (o_m_tdata),
        .o_m_tid              (o_m_tid),
        .o_m_tlast            (o_m_tlast),
        .o_kernel_loaded      (o_kernel_loaded),
        .o_busy               (o_busy),
        .o_err                (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       s0_frames;
        int       s1_frames;
        int       nframes;
        logic [3:0] exp_ids;   // bit f = expected requester of frame f
        bit       gap_chk;
    } vec_t;

    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;

    // Bench-side requester / core / sink model state
    int s0_left, s1_left;
    int cur_beat, cur_id, fbad;
    int out_beat, obad;
    int frames_in, frames_out;
    int cyc, last_end;
    bit gap_chk, out_en, m_ready;
    int exp_q[$];
    int core_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock cycle of the whole environment: drive, sample at negedge,
    // update the models, then return at posedge+1.
    task automatic step();
        int id;
        int e;
        logic [W-1:0]  exp_d;
        logic [OW-1:0] exp_o;
        i_s0_tvalid       = (s0_left > 0);
        i_s1_tvalid       = (s1_left > 0);
        i_s0_tdata        = W'(2 * cur_beat);
        i_s1_tdata        = W'(16'h1000 + cur_beat);
        i_conv_out_tvalid = out_en && (core_q.size() > 0);
        i_conv_out_tdata  = (core_q.size() > 0) ?
                            {(core_q[0] == 1) ? 8'hB1 : 8'hB0, 8'(out_beat)} : '0;
        i_m_tready        = m_ready;
        @(negedge clk);
        if (o_conv_tvalid && i_conv_tready) begin
            id = o_s1_tready ? 1 : 0;
            if (o_s0_tready == o_s1_tready) fbad++;
            if (cur_beat == 0) begin
                cur_id = id;
                if (gap_chk && last_end >= 0) chk("idle_gap", cyc - last_end, 2);
            end else if (id != cur_id) begin
                fbad++;
            end
            exp_d = (cur_id == 1) ? W'(16'h1000 + cur_beat) : W'(2 * cur_beat);
            if (o_conv_tdata !== exp_d) fbad++;
            cur_beat++;
            if (cur_beat == IN_BEATS) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
                chk("grant_order", cur_id, e);
                chk("frame_in_data", fbad, 0);
                core_q.push_back(e);
                if (cur_id == 1 && s1_left > 0) s1_left--;
                if (cur_id == 0 && s0_left > 0) s0_left--;
                cur_beat = 0;
                fbad     = 0;
                last_end = cyc;
                frames_in++;
            end
        end
        if (i_conv_out_tvalid && o_conv_out_tready) begin
            exp_o = i_conv_out_tdata;
            if (o_m_tvalid !== 1'b1) obad++;
            if (o_m_tid !== 1'(core_q[0])) obad++;
            if (o_m_tlast !== (out_beat == OUT_BEATS - 1)) obad++;
            if (o_m_tdata !== exp_o) obad++;
            out_beat++;
            if (out_beat == OUT_BEATS) begin
                chk("out_frame_tag", obad, 0);
                void'(core_q.pop_front());
                out_beat = 0;
                obad     = 0;
                frames_out++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int ti, input int to, input int budget);
        int n = 0;
        while ((frames_in < ti || frames_out < to) && n < budget) begin
            step();
            n++;
        end
        chk("frames_in", frames_in, ti);
        chk("frames_out", frames_out, to);
    endtask

    task automatic load_kernel(output int n, output int bad);
        n   = 0;
        bad = 0;
        i_kernel_tvalid      = 1'b1;
        i_conv_kernel_tready = 1'b1;
        for (int c = 0; c < 300 && n < KERN_BEATS; c++) begin
            i_kernel_tdata = KW'(32'hC0DE0000 + n);
            @(negedge clk);
            if (o_kernel_loaded !== 1'b0) bad++;
            if (o_kernel_tready !== o_conv_kernel_tvalid) bad++;
            if (o_kernel_tready && o_conv_kernel_tvalid) begin
                if (o_conv_kernel_tdata !== i_kernel_tdata) bad++;
                n++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("kernel_tready_after_last", o_kernel_tready, 0);
        chk("kernel_loaded", o_kernel_loaded, 1);
        @(posedge clk);
        #1;
        i_kernel_tvalid = 1'b0;
    endtask

    initial begin
        int n, bad;
        rst = 1'b1;
        i_kernel_tvalid = 0; i_kernel_tdata = '0; i_kernel_reload = 0;
        i_s0_tvalid = 0; i_s0_tdata = '0; i_s1_tvalid = 0; i_s1_tdata = '0;
        i_conv_kernel_tready = 0; i_conv_tready = 1;
        i_conv_out_tvalid = 0; i_conv_out_tdata = '0; i_m_tready = 0;
        s0_left = 0; s1_left = 0; cur_beat = 0; cur_id = 0; fbad = 0;
        out_beat = 0; obad = 0; frames_in = 0; frames_out = 0;
        cyc = 0; last_end = -1; gap_chk = 0; out_en = 1; m_ready = 1;

        //          s0 s1 n  ids      gap
        vecs[0] = '{1, 0, 1, 4'b0000, 1'b0};   // s0 only
        vecs[1] = '{0, 1, 1, 4'b0001, 1'b0};   // s1 only
        vecs[2] = '{2, 2, 4, 4'b1010, 1'b1};   // both: 0,1,0,1
        vecs[3] = '{1, 0, 1, 4'b0000, 1'b0};   // s0 only, leaves rr on s1
        vecs[4] = '{1, 1, 2, 4'b0001, 1'b1};   // both: 1,0
        vecs[5] = '{0, 1, 1, 4'b0001, 1'b0};   // s1 only

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_kernel_loaded", o_kernel_loaded, 0);
        chk("rst_err", o_err, 0);
        chk("rst_m_tid", o_m_tid, 0);
        chk("rst_m_tlast", o_m_tlast, 0);
        chk("rst_m_tvalid", o_m_tvalid, 0);
        chk("rst_kernel_tready", o_kernel_tready, 0);
        chk("rst_s0_tready", o_s0_tready, 0);
        chk("rst_conv_tvalid", o_conv_tvalid, 0);
        chk("rst_busy", o_busy, 1);

        // Initial kernel load
        load_kernel(n, bad);
        chk("kernel_beats", n, KERN_BEATS);
        chk("kernel_data", bad, 0);
        chk("idle_not_busy", o_busy, 0);

        // Arbitration table
        for (int v = 0; v < 6; v++) begin
            s0_left = vecs[v].s0_frames;
            s1_left = vecs[v].s1_frames;
            for (int f = 0; f < vecs[v].nframes; f++) exp_q.push_back(int'(vecs[v].exp_ids[f]));
            gap_chk = vecs[v].gap_chk;
            frames_in = 0; frames_out = 0; last_end = -1;
            run_until(vecs[v].nframes, vecs[v].nframes, 2000);
        end
        gap_chk = 0;

        // Reload mid-frame with a second frame queued
        s0_left = 1; s1_left = 1; exp_q.push_back(0); exp_q.push_back(1);
        frames_in = 0; frames_out = 0;
        for (int c = 0; c < 200 && !(frames_in == 0 && cur_beat == 20); c++) step();
        i_kernel_reload = 1'b1;
        step();
        i_kernel_reload = 1'b0;
        for (int c = 0; c < 200 && frames_in < 1; c++) step();
        repeat (60) step();
        chk("reload_no_grant_beats", cur_beat, 0);
        chk("reload_no_grant_frames", frames_in, 1);
        chk("reload_first_drained", frames_out, 1);
        chk("reload_loaded_cleared", o_kernel_loaded, 0);
        chk("reload_busy", o_busy, 1);
        load_kernel(n, bad);
        chk("reload_kernel_beats", n, KERN_BEATS);
        chk("reload_kernel_data", bad, 0);
        run_until(2, 2, 2000);

        // FIFO full: four frames held at the sink, fifth grant withheld
        m_ready = 0;
        s0_left = 3; s1_left = 2;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(0);
        frames_in = 0; frames_out = 0;
        for (int c = 0; c < 1000 && frames_in < 4; c++) step();
        repeat (30) step();
        chk("full_frames_in", frames_in, 4);
        chk("full_no_beats", cur_beat, 0);
        chk("full_s0_tready", o_s0_tready, 0);
        chk("full_frames_out", frames_out, 0);
        m_ready = 1;
        run_until(5, 5, 3000);
        chk("err_clear_before", o_err, 0);
        chk("drained_not_busy", o_busy, 0);

        // Core output with nothing in flight
        i_conv_out_tvalid = 1'b1;
        i_conv_out_tdata  = 16'hDEAD;
        @(negedge clk);
        chk("orphan_m_tvalid", o_m_tvalid, 0);
        chk("orphan_tready", o_conv_out_tready, 1);
        chk("orphan_err_not_yet", o_err, 0);
        @(posedge clk);
        #1;
        i_conv_out_tvalid = 1'b0;
        @(negedge clk);
        chk("orphan_err_set", o_err, 1);
        @(posedge clk);
        #1;
        repeat (5) step();
        chk("err_sticky", o_err, 1);

        // Asynchronous reset in the middle of a frame
        s0_left = 1; exp_q.push_back(0); frames_in = 0; frames_out = 0;
        for (int c = 0; c < 100 && cur_beat != 10; c++) step();
        chk("pre_reset_midframe", cur_beat, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_err", o_err, 0);
        chk("areset_kernel_loaded", o_kernel_loaded, 0);
        chk("areset_s0_tready", o_s0_tready, 0);
        chk("areset_conv_tvalid", o_conv_tvalid, 0);
        chk("areset_m_tlast", o_m_tlast, 0);
        chk("areset_busy", o_busy, 1);
        s0_left = 0; s1_left = 0; exp_q.delete(); core_q.delete();
        cur_beat = 0; fbad = 0; out_beat = 0; obad = 0;
        i_s0_tvalid = 0; i_s1_tvalid = 0; i_conv_out_tvalid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_kernel(n, bad);
        chk("post_reset_kernel_beats", n, KERN_BEATS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
